stroke_capture: RTL and testbench

STROKE_CAPTURE -- requirements
Module: stroke_capture

---
 rtl/stroke_capture_pkg.sv | 29 ++
 rtl/stroke_capture_cell_locator.sv | 35 +++
 rtl/stroke_capture.sv | 155 +++++++++++++++
 tb/tb_stroke_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stroke_capture_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stroke_capture_pkg                                                        |
// | Shared FSM state type and width helpers for the stroke capture block.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package stroke_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int c_CNT_W = 32;

  // A 1x1 grid still needs a one-bit cell index port.
  function automatic int cell_idx_w(input int grid);
    int w;
    w = $clog2(grid * grid);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int bitmap_w(input int size);
    return size * size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stroke_capture_cell_locator.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cell_locator                                                              |
// | Maps a pointer position to grid cell, local offset and latched-cell hit.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module cell_locator #(
  parameter int SIZE = 52,
  parameter int GRID = 9
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] cell_col,
  input  logic [9:0] cell_row,
  output logic       in_grid,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic [9:0] lx,
  output logic [9:0] ly,
  output logic       in_cell
);

  localparam logic [31:0] c_SPAN = 32'(SIZE * GRID);
  localparam logic [31:0] c_SIZE = 32'(SIZE);

  assign in_grid = (32'(x) < c_SPAN) && (32'(y) < c_SPAN);
  assign col     = 10'(32'(x) / c_SIZE);
  assign row     = 10'(32'(y) / c_SIZE);
  // Offsets relative to the latched cell origin; meaningful only when in_cell.
  assign lx      = 10'(32'(x) - 32'(cell_col) * c_SIZE);
  assign ly      = 10'(32'(y) - 32'(cell_row) * c_SIZE);
  assign in_cell = in_grid && (col == cell_col) && (row == cell_row);

endmodule
`default_nettype wire

// File: rtl/stroke_capture.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stroke_capture                                                            |
// | Captures one mouse stroke into a per-cell bitmap and hands it off.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module stroke_capture
  import stroke_capture_pkg::*;
#(
  parameter int SIZE        = 52,
  parameter int GRID        = 9,
  parameter int MAXCNT      = 150000000,
  parameter int IDLE_CYCLES = 25000000,
  parameter int BRUSH       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    MOUSE_X_POS,
  input  logic [9:0]                    MOUSE_Y_POS,
  input  logic                          MOUSE_LEFT,
  input  logic                          cancel,
  input  logic                          ready,
  output logic                          valid,
  output logic [cell_idx_w(GRID)-1:0]   block_pos,
  output logic [bitmap_w(SIZE)-1:0]     track,
  output logic                          timeout,
  output logic                          busy
);

  localparam int c_IDX_W = cell_idx_w(GRID);
  localparam int c_TRK_W = bitmap_w(SIZE);
  localparam int c_PIX_W = $clog2(c_TRK_W);
  localparam logic [c_CNT_W-1:0] c_DRAW_LAST = c_CNT_W'(MAXCNT - 1);
  localparam logic [c_CNT_W-1:0] c_REL_LAST  = c_CNT_W'(IDLE_CYCLES - 1);

  state_t               r_state, w_next;
  logic [9:0]           r_col, r_row;
  logic [c_IDX_W-1:0]   r_block_pos;
  logic [c_TRK_W-1:0]   r_track;
  logic                 r_timeout;
  logic [c_CNT_W-1:0]   r_draw_cnt, r_rel_cnt;

  logic                 w_in_grid, w_in_cell;
  logic [9:0]           w_col, w_row, w_lx, w_ly;
  logic [31:0]          w_base;
  logic [c_TRK_W-1:0]   w_mask;
  logic                 w_start, w_end_t, w_end_r;

  cell_locator #(.SIZE(SIZE), .GRID(GRID)) u_loc (
    .x        (MOUSE_X_POS),
    .y        (MOUSE_Y_POS),
    .cell_col (r_col),
    .cell_row (r_row),
    .in_grid  (w_in_grid),
    .col      (w_col),
    .row      (w_row),
    .lx       (w_lx),
    .ly       (w_ly),
    .in_cell  (w_in_cell)
  );

  assign w_start = MOUSE_LEFT && w_in_grid;
  assign w_end_t = (r_draw_cnt == c_DRAW_LAST);
  assign w_end_r = !MOUSE_LEFT && (r_rel_cnt == c_REL_LAST);
  assign w_base  = 32'(w_ly) * 32'(SIZE) + 32'(w_lx);

  // Neighbour bits are clipped at the cell edge so they never wrap rows.
  if (BRUSH != 0) begin : g_brush
    always_comb begin
      w_mask = '0;
      if (MOUSE_LEFT && w_in_cell) begin
        w_mask[c_PIX_W'(w_base)] = 1'b1;
        if (w_lx != 10'd0)                w_mask[c_PIX_W'(w_base - 32'd1)]       = 1'b1;
        if (32'(w_lx) < 32'(SIZE - 1))    w_mask[c_PIX_W'(w_base + 32'd1)]       = 1'b1;
        if (w_ly != 10'd0)                w_mask[c_PIX_W'(w_base - 32'(SIZE))]   = 1'b1;
        if (32'(w_ly) < 32'(SIZE - 1))    w_mask[c_PIX_W'(w_base + 32'(SIZE))]   = 1'b1;
      end
    end
  end else begin : g_pixel
    always_comb begin
      w_mask = '0;
      if (MOUSE_LEFT && w_in_cell) w_mask[c_PIX_W'(w_base)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // cancel outranks both stroke-end conditions.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_DRAW;
      ST_DRAW: begin
        if (cancel)                  w_next = ST_IDLE;
        else if (w_end_t || w_end_r) w_next = ST_HOLD;
      end
      ST_HOLD: if (ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    case (r_state)
      ST_DRAW: busy  = 1'b1;
      ST_HOLD: valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_block_pos <= '0;
      r_track     <= '0;
      r_timeout   <= 1'b0;
      r_draw_cnt  <= '0;
      r_rel_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_col       <= w_col;
          r_row       <= w_row;
          r_block_pos <= c_IDX_W'(32'(w_row) * 32'(GRID) + 32'(w_col));
          r_track     <= '0;
          r_timeout   <= 1'b0;
          r_draw_cnt  <= '0;
          r_rel_cnt   <= '0;
        end
        ST_DRAW: begin
          if (cancel) begin
            r_track <= '0;
          end else begin
            r_track    <= r_track | w_mask;
            r_draw_cnt <= r_draw_cnt + 1'b1;
            r_rel_cnt  <= MOUSE_LEFT ? '0 : r_rel_cnt + 1'b1;
            if (w_end_t || w_end_r) r_timeout <= w_end_t;
          end
        end
        default: ;
      endcase
    end
  end

  assign block_pos = r_block_pos;
  assign track     = r_track;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_stroke_capture.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_stroke_capture                                                         |
// | Directed + random stimulus against a behavioural stroke model.            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_stroke_capture;

  localparam int c_SZ   = 52;
  localparam int c_GR   = 9;
  localparam int c_MAX  = 1000;
  localparam int c_IDL  = 16;
  localparam int c_TW   = c_SZ * c_SZ;
  localparam int c_SPAN = c_SZ * c_GR;

  logic            clk = 1'b0;
  logic            rst;
  logic [9:0]      mx, my;
  logic            ml, cn, rd;
  logic            valid0, valid1, to0, to1, busy0, busy1;
  logic [6:0]      bp0, bp1;
  logic [c_TW-1:0] trk0, trk1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: mode 0 idle, 1 drawing, 2 holding a result.
  int            m_mode [2];
  int            m_cell [2];
  int            m_dcnt [2];
  int            m_rel  [2];
  bit            m_to   [2];
  bit [c_TW-1:0] m_trk  [2];

  stroke_capture #(.SIZE(c_SZ), .GRID(c_GR), .MAXCNT(c_MAX), .IDLE_CYCLES(c_IDL), .BRUSH(0)) u_dut0 (
    .clk(clk), .rst(rst), .MOUSE_X_POS(mx), .MOUSE_Y_POS(my), .MOUSE_LEFT(ml),
    .cancel(cn), .ready(rd), .valid(valid0), .block_pos(bp0), .track(trk0),
    .timeout(to0), .busy(busy0));

  stroke_capture #(.SIZE(c_SZ), .GRID(c_GR), .MAXCNT(c_MAX), .IDLE_CYCLES(c_IDL), .BRUSH(1)) u_dut1 (
    .clk(clk), .rst(rst), .MOUSE_X_POS(mx), .MOUSE_Y_POS(my), .MOUSE_LEFT(ml),
    .cancel(cn), .ready(rd), .valid(valid1), .block_pos(bp1), .track(trk1),
    .timeout(to1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_trk(input string tag, input logic [c_TW-1:0] obs, input logic [c_TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed_ones=%0d expected_ones=%0d", tag, cyc,
             $countones(obs), $countones(exp));
    end
  endtask

  task automatic set_px(input int b, input int lx, input int ly);
    if (lx >= 0 && lx < c_SZ && ly >= 0 && ly < c_SZ) m_trk[b][ly * c_SZ + lx] = 1'b1;
  endtask

  task automatic model_step(input int b);
    int xi, yi;
    bit end_t, end_r;
    xi = int'(mx);
    yi = int'(my);
    if (rst) begin
      m_mode[b] = 0; m_cell[b] = 0; m_dcnt[b] = 0; m_rel[b] = 0; m_to[b] = 0; m_trk[b] = '0;
    end else if (m_mode[b] == 0) begin
      if (ml && xi < c_SPAN && yi < c_SPAN) begin
        m_mode[b] = 1; m_cell[b] = (yi / c_SZ) * c_GR + xi / c_SZ;
        m_trk[b] = '0; m_to[b] = 0; m_dcnt[b] = 0; m_rel[b] = 0;
      end
    end else if (m_mode[b] == 1) begin
      if (cn) begin
        m_mode[b] = 0; m_trk[b] = '0;
      end else begin
        if (ml && xi < c_SPAN && yi < c_SPAN &&
            xi / c_SZ == m_cell[b] % c_GR && yi / c_SZ == m_cell[b] / c_GR) begin
          set_px(b, xi % c_SZ, yi % c_SZ);
          if (b == 1) begin
            set_px(b, xi % c_SZ - 1, yi % c_SZ);
            set_px(b, xi % c_SZ + 1, yi % c_SZ);
            set_px(b, xi % c_SZ, yi % c_SZ - 1);
            set_px(b, xi % c_SZ, yi % c_SZ + 1);
          end
        end
        end_t = (m_dcnt[b] + 1 == c_MAX);
        end_r = !ml && (m_rel[b] + 1 == c_IDL);
        if (end_t || end_r) begin
          m_mode[b] = 2; m_to[b] = end_t;
        end
        m_dcnt[b]++;
        m_rel[b] = ml ? 0 : m_rel[b] + 1;
      end
    end else if (rd) begin
      m_mode[b] = 0;
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cyc++;
    chk("valid0", 32'(valid0), 32'(m_mode[0] == 2));
    chk("busy0",  32'(busy0),  32'(m_mode[0] == 1));
    chk("bpos0",  32'(bp0),    32'(m_cell[0]));
    chk("tmo0",   32'(to0),    32'(m_to[0]));
    chk_trk("track0", trk0, m_trk[0]);
    chk("valid1", 32'(valid1), 32'(m_mode[1] == 2));
    chk("busy1",  32'(busy1),  32'(m_mode[1] == 1));
    chk("bpos1",  32'(bp1),    32'(m_cell[1]));
    chk("tmo1",   32'(to1),    32'(m_to[1]));
    chk_trk("track1", trk1, m_trk[1]);
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int n;
    n = 0;
    while (valid0 !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(valid0), 32'd1);
  endtask

  task automatic drain();
    ml = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    logic [c_TW-1:0] snap;
    logic [6:0]      snap_bp;
    int              ax, ay, t, c, seen;

    for (int b = 0; b < 2; b++) begin
      m_mode[b] = 0; m_cell[b] = 0; m_dcnt[b] = 0; m_rel[b] = 0; m_to[b] = 0; m_trk[b] = '0;
    end
    rst = 1'b1; mx = '0; my = '0; ml = 1'b1; cn = 1'b0; rd = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 32'(valid0), 32'd0);
    chk("reset_busy",  32'(busy0),  32'd0);
    chk("reset_track", 32'($countones(trk0)), 32'd0);
    rst = 1'b0; ml = 1'b0;
    tick();

    // Short press in cell 1, then release until expiry.
    mx = 10'd60; my = 10'd10; ml = 1'b1;
    repeat (3) tick();
    ml = 1'b0;
    wait_valid(40, "release_end_valid");
    chk("release_end_bpos", 32'(bp0), 32'd1);
    chk("release_end_bit528", 32'(trk0[528]), 32'd1);
    chk("release_end_tmo", 32'(to0), 32'd0);
    drain();
    chk("release_end_valid_drop", 32'(valid0), 32'd0);

    // Bottom-right corner held until the duration limit.
    mx = 10'd467; my = 10'd467; ml = 1'b1;
    wait_valid(1100, "maxcnt_valid");
    chk("maxcnt_bpos", 32'(bp0), 32'd80);
    chk("maxcnt_bit2703", 32'(trk0[2703]), 32'd1);
    chk("maxcnt_tmo", 32'(to0), 32'd1);
    drain();

    // Out-of-grid press, then drag out of cell 0.
    mx = 10'd468; my = 10'd0; ml = 1'b1;
    repeat (5) tick();
    chk("outgrid_busy", 32'(busy0), 32'd0);
    mx = 10'd10;
    repeat (2) tick();
    mx = 10'd52;
    repeat (2) tick();
    ml = 1'b0;
    wait_valid(40, "drag_valid");
    chk("drag_bit52", 32'(trk0[52]), 32'd0);
    chk("drag_bit10", 32'(trk0[10]), 32'd1);
    drain();

    // Plus brush at the bottom-left pixel of cell 0, then hold with ready low.
    mx = 10'd0; my = 10'd51; ml = 1'b1;
    repeat (2) tick();
    ml = 1'b0;
    wait_valid(40, "brush_valid");
    chk("brush_b2652", 32'(trk1[2652]), 32'd1);
    chk("brush_b2653", 32'(trk1[2653]), 32'd1);
    chk("brush_b2600", 32'(trk1[2600]), 32'd1);
    chk("brush_ones", 32'($countones(trk1)), 32'd3);
    snap = trk0; snap_bp = bp0;
    for (int i = 0; i < 50; i++) begin
      mx = 10'($urandom_range(467, 0)); my = 10'($urandom_range(467, 0)); ml = 1'b1;
      tick();
    end
    chk_trk("hold_track_stable", trk0, snap);
    chk("hold_bpos_stable", 32'(bp0), 32'(snap_bp));
    chk("hold_valid_kept", 32'(valid0), 32'd1);
    drain();
    chk("hold_valid_drop", 32'(valid0), 32'd0);

    // cancel mid-stroke, and cancel on the release-expiry cycle.
    seen = 0;
    mx = 10'd100; my = 10'd100; ml = 1'b1;
    repeat (3) tick();
    cn = 1'b1; tick(); cn = 1'b0;
    chk("cancel_busy", 32'(busy0), 32'd0);
    chk("cancel_track", 32'($countones(trk0)), 32'd0);
    ml = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (valid0 === 1'b1) seen++; end
    ml = 1'b1; repeat (2) tick();
    ml = 1'b0; repeat (15) tick();
    cn = 1'b1; tick(); cn = 1'b0;
    if (valid0 === 1'b1) seen++;
    for (int i = 0; i < 5; i++) begin tick(); if (valid0 === 1'b1) seen++; end
    chk("cancel_no_valid", 32'(seen), 32'd0);

    // Reset mid-DRAW and mid-HOLD.
    ml = 1'b1; repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0; ml = 1'b0;
    chk("rst_draw_busy", 32'(busy0), 32'd0);
    chk("rst_draw_track", 32'($countones(trk0)), 32'd0);
    ml = 1'b1; repeat (3) tick(); ml = 1'b0;
    wait_valid(40, "pre_rst_hold_valid");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_hold_valid", 32'(valid0), 32'd0);
    tick();

    // Random wandering around anchor cells.
    ax = 0; ay = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99, 0) == 0) begin
        c = int'($urandom_range(81, 0));
        ax = (c % c_GR) * c_SZ; ay = (c / c_GR) * c_SZ;
      end
      if ($urandom_range(9, 0) == 0) ml = !ml;
      t = ax + int'($urandom_range(71, 0)) - 10;
      t = (t < 0) ? 0 : (t > 1023 ? 1023 : t);
      mx = t[9:0];
      t = ay + int'($urandom_range(71, 0)) - 10;
      t = (t < 0) ? 0 : (t > 1023 ? 1023 : t);
      my = t[9:0];
      cn  = ($urandom_range(199, 0) == 0);
      rd  = ($urandom_range(7, 0) == 0);
      rst = ($urandom_range(999, 0) == 0);
      tick();
    end
    cn = 1'b0; rst = 1'b0; rd = 1'b0; ml = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
